// File: rtl/boreal_feat_pkg.sv
// Shared types and helpers for the boreal spatial feature accumulator.
package boreal_feat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Width used for the shift/saturate helper; any accumulator fits in it.
    localparam int WIDE_W = 64;

    // Accumulator width: full product plus headroom for NUM_CH additions.
    function automatic int calc_acc_w(input int sample_w, input int weight_w, input int num_ch);
        return sample_w + weight_w + $clog2(num_ch);
    endfunction

    // Arithmetic right shift followed by clamping to a signed feat_w range.
    function automatic logic signed [WIDE_W-1:0] sat_shift(
        input logic signed [WIDE_W-1:0] acc,
        input int                       shift,
        input int                       feat_w
    );
        logic signed [WIDE_W-1:0] shifted;
        logic signed [WIDE_W-1:0] max_v;
        logic signed [WIDE_W-1:0] min_v;
        shifted = acc >>> shift;
        max_v   = (64'sd1 <<< (feat_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (feat_w - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

    // X weights alternate sign: -1 on even channels, +1 on odd channels.
    function automatic int wx_reset(input int c);
        return ((c % 2) == 1) ? 1 : -1;
    endfunction

    // Y weights split the montage: -1 on the lower half, +1 on the upper half.
    function automatic int wy_reset(input int c, input int num_ch);
        return (c >= (num_ch / 2)) ? 1 : -1;
    endfunction

endpackage

// File: rtl/boreal_feature_frame_if.sv
// Sample, weight-write and feature/status signals of the feature accumulator.
interface boreal_feature_frame_if #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 16,
    parameter int WEIGHT_W = 8,
    parameter int FEAT_W   = 16
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                       s_valid;
    logic [CH_W-1:0]            s_ch;
    logic signed [SAMPLE_W-1:0] s_sample;

    logic                       wr_en;
    logic                       wr_axis;
    logic [CH_W-1:0]            wr_ch;
    logic signed [WEIGHT_W-1:0] wr_data;

    logic                       feat_valid;
    logic signed [FEAT_W-1:0]   feat_x;
    logic signed [FEAT_W-1:0]   feat_y;
    logic                       frame_err;
    logic [7:0]                 err_count;
    logic                       busy;

    modport master (
        output s_valid, s_ch, s_sample,
        output wr_en, wr_axis, wr_ch, wr_data,
        input  feat_valid, feat_x, feat_y, frame_err, err_count, busy
    );

    modport slave (
        input  s_valid, s_ch, s_sample,
        input  wr_en, wr_axis, wr_ch, wr_data,
        output feat_valid, feat_x, feat_y, frame_err, err_count, busy
    );
endinterface

// File: rtl/boreal_weight_bank.sv
// Runtime-programmable X/Y weight register file, one write port, two read ports.
module boreal_weight_bank
    import boreal_feat_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int WEIGHT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic                       wr_axis,
    input  logic [$clog2(NUM_CH)-1:0]  wr_ch,
    input  logic signed [WEIGHT_W-1:0] wr_data,
    input  logic [$clog2(NUM_CH)-1:0]  rd_ch,
    output logic signed [WEIGHT_W-1:0] rd_wx,
    output logic signed [WEIGHT_W-1:0] rd_wy
);
    logic signed [WEIGHT_W-1:0] w_x [NUM_CH];
    logic signed [WEIGHT_W-1:0] w_y [NUM_CH];

    // Reads are combinational, so a same-cycle write is seen only by later samples.
    assign rd_wx = w_x[rd_ch];
    assign rd_wy = w_y[rd_ch];

    // Weight storage: reset pattern, then single-entry writes selected by axis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                w_x[c] <= WEIGHT_W'(wx_reset(c));
                w_y[c] <= WEIGHT_W'(wy_reset(c, NUM_CH));
            end
        end else if (wr_en) begin
            if (wr_axis) begin
                w_y[wr_ch] <= wr_data;
            end else begin
                w_x[wr_ch] <= wr_data;
            end
        end
    end
endmodule

// File: rtl/boreal_feature_frame.sv
// N-channel spatial feature accumulator: frame FSM, X/Y accumulators, idle timer.
//
// state | meaning
// IDLE  | waiting for channel 0 to open a frame
// ACCUM | frame open, expecting channel exp_ch next
// EMIT  | frame complete, registering saturated features (one cycle)
module boreal_feature_frame
    import boreal_feat_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 16,
    parameter int WEIGHT_W = 8,
    parameter int FEAT_W   = 16,
    parameter int SHIFT    = 3,
    parameter int TIMEOUT  = 4096
) (
    input logic                  clk,
    input logic                  rst_n,
    boreal_feature_frame_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = calc_acc_w(SAMPLE_W, WEIGHT_W, NUM_CH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t                     state;
    logic [CH_W-1:0]            exp_ch;
    logic [TMR_W-1:0]           tmr;
    logic signed [ACC_W-1:0]    acc_x;
    logic signed [ACC_W-1:0]    acc_y;
    logic signed [WEIGHT_W-1:0] wx;
    logic signed [WEIGHT_W-1:0] wy;
    logic signed [ACC_W-1:0]    prod_x;
    logic signed [ACC_W-1:0]    prod_y;
    logic                       start;
    logic [7:0]                 err_cnt_q;
    logic [7:0]                 err_cnt_next;
    logic                       feat_valid_q;
    logic                       frame_err_q;
    logic                       busy_q;
    logic signed [FEAT_W-1:0]   feat_x_q;
    logic signed [FEAT_W-1:0]   feat_y_q;

    boreal_weight_bank #(
        .NUM_CH   (NUM_CH),
        .WEIGHT_W (WEIGHT_W)
    ) u_weights (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_axis (bus.wr_axis),
        .wr_ch   (bus.wr_ch),
        .wr_data (bus.wr_data),
        .rd_ch   (bus.s_ch),
        .rd_wx   (wx),
        .rd_wy   (wy)
    );

    // Sign-extend both operands to the accumulator width before multiplying.
    assign prod_x       = ACC_W'(bus.s_sample) * ACC_W'(wx);
    assign prod_y       = ACC_W'(bus.s_sample) * ACC_W'(wy);
    assign start        = bus.s_valid && (bus.s_ch == '0);
    assign err_cnt_next = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    assign bus.feat_valid = feat_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.feat_x     = feat_x_q;
    assign bus.feat_y     = feat_y_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.busy       = busy_q;

    // Frame sequencing, accumulation, idle timeout and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            exp_ch       <= '0;
            tmr          <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            err_cnt_q    <= '0;
            feat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            feat_x_q     <= '0;
            feat_y_q     <= '0;
        end else begin
            feat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc_x  <= prod_x;
                        acc_y  <= prod_y;
                        exp_ch <= CH_W'(1);
                        tmr    <= TMR_LOAD;
                        busy_q <= 1'b1;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.s_valid) begin
                        if (bus.s_ch == exp_ch) begin
                            acc_x  <= acc_x + prod_x;
                            acc_y  <= acc_y + prod_y;
                            exp_ch <= exp_ch + CH_W'(1);
                            tmr    <= TMR_LOAD;
                            if (exp_ch == LAST_CH) begin
                                busy_q <= 1'b0;
                                state  <= ST_EMIT;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            err_cnt_q   <= err_cnt_next;
                            if (start) begin
                                // A fresh channel 0 restarts the frame rather than dropping it.
                                acc_x  <= prod_x;
                                acc_y  <= prod_y;
                                exp_ch <= CH_W'(1);
                                tmr    <= TMR_LOAD;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end else if (tmr == '0) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= err_cnt_next;
                        busy_q      <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_EMIT: begin
                    feat_x_q     <= FEAT_W'(sat_shift(WIDE_W'(acc_x), SHIFT, FEAT_W));
                    feat_y_q     <= FEAT_W'(sat_shift(WIDE_W'(acc_y), SHIFT, FEAT_W));
                    feat_valid_q <= 1'b1;
                    if (start) begin
                        acc_x  <= prod_x;
                        acc_y  <= prod_y;
                        exp_ch <= CH_W'(1);
                        tmr    <= TMR_LOAD;
                        busy_q <= 1'b1;
                        state  <= ST_ACCUM;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boreal_feature_frame.sv
// Scoreboard bench for boreal_feature_frame (8 channels, 16-cycle timeout).
module tb_boreal_feature_frame;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 16;
    localparam int WEIGHT_W = 8;
    localparam int FEAT_W   = 16;
    localparam int SHIFT    = 3;
    localparam int TIMEOUT  = 16;
    localparam int CH_W     = $clog2(NUM_CH);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boreal_feature_frame_if #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WEIGHT_W(WEIGHT_W), .FEAT_W(FEAT_W)
    ) bus ();

    boreal_feature_frame #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .WEIGHT_W(WEIGHT_W),
        .FEAT_W(FEAT_W), .SHIFT(SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint x;
        longint y;
        int     cyc;
    } exp_t;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    int   n_err_pulse = 0;
    int   exp_err = 0;
    int   mwx [NUM_CH];
    int   mwy [NUM_CH];
    exp_t sb [$];
    int   strobe_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint act, input longint want);
        n_cmp++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mwx[c] = ((c % 2) == 1) ? 1 : -1;
            mwy[c] = (c >= NUM_CH / 2) ? 1 : -1;
        end
        exp_err = 0;
    endtask

    function automatic longint model_feat(input int smp [NUM_CH], input bit axis);
        longint s;
        longint hi;
        s = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            s += longint'(smp[c]) * longint'(axis ? mwy[c] : mwx[c]);
        end
        s  = s >>> SHIFT;
        hi = (longint'(1) <<< (FEAT_W - 1)) - 1;
        if (s > hi) s = hi;
        if (s < -hi - 1) s = -hi - 1;
        return s;
    endfunction

    task automatic drive(input bit v, input int ch, input int smp,
                         input bit we = 1'b0, input bit wax = 1'b0,
                         input int wch = 0, input int wd = 0);
        @(negedge clk);
        bus.s_valid  = v;
        bus.s_ch     = CH_W'(ch);
        bus.s_sample = SAMPLE_W'(smp);
        bus.wr_en    = we;
        bus.wr_axis  = wax;
        bus.wr_ch    = CH_W'(wch);
        bus.wr_data  = WEIGHT_W'(wd);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    task automatic write_w(input bit ax, input int ch, input int d);
        drive(1'b0, 0, 0, 1'b1, ax, ch, d);
        if (ax) mwy[ch] = d;
        else    mwx[ch] = d;
    endtask

    // Expected features are taken before any mid-frame write lands in the model.
    task automatic send_frame(input int smp [NUM_CH], input int wr_at = -1,
                              input bit wax = 1'b0, input int wch = 0, input int wd = 0);
        exp_t e;
        e.x = model_feat(smp, 1'b0);
        e.y = model_feat(smp, 1'b1);
        for (int c = 0; c < NUM_CH; c++) begin
            drive(1'b1, c, smp[c], (c == wr_at), wax, wch, wd);
            if (c == NUM_CH - 1) begin
                e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        if (wr_at >= 0) begin
            if (wax) mwy[wch] = wd;
            else     mwx[wch] = wd;
        end
    endtask

    // Output monitor: pops the scoreboard on each feature strobe, tracks error pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.feat_valid || bus.frame_err)
                    check_val("strobe_excl", longint'(bus.feat_valid && bus.frame_err), 0);
                if (bus.feat_valid) begin
                    n_strobe++;
                    strobe_cyc.push_back(cyc);
                    check_val("sb_pending", longint'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_val("feat_x", longint'(bus.feat_x), e.x);
                        check_val("feat_y", longint'(bus.feat_y), e.y);
                        check_val("feat_cycle", cyc, e.cyc);
                    end
                end
                if (bus.frame_err) n_err_pulse++;
            end
        end
    end

    initial begin
        int f [NUM_CH];
        int f2 [NUM_CH];
        int e0;
        int s0;
        exp_t e;

        rst_n        = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_ch     = '0;
        bus.s_sample = '0;
        bus.wr_en    = 1'b0;
        bus.wr_axis  = 1'b0;
        bus.wr_ch    = '0;
        bus.wr_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_feat_valid", longint'(bus.feat_valid), 0);
        check_val("rst_frame_err", longint'(bus.frame_err), 0);
        check_val("rst_feat_x", longint'(bus.feat_x), 0);
        check_val("rst_feat_y", longint'(bus.feat_y), 0);
        check_val("rst_err_count", longint'(bus.err_count), 0);
        check_val("rst_busy", longint'(bus.busy), 0);
        rst_n = 1'b1;
        idle(1);

        // Ramp with default weights: sums 40 and 160 give 5 and 20.
        for (int c = 0; c < NUM_CH; c++) begin
            drive(1'b1, c, 10 * c);
            if (c == NUM_CH - 1) begin
                e.x = 5; e.y = 20; e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        idle(4);
        check_val("ramp_busy", longint'(bus.busy), 0);
        check_val("ramp_hold_x", longint'(bus.feat_x), 5);
        check_val("ramp_hold_y", longint'(bus.feat_y), 20);
        check_val("ramp_strobes", n_strobe, 1);

        // Saturation in both directions.
        for (int c = 0; c < NUM_CH; c++) write_w(1'b0, c, 127);
        for (int c = 0; c < NUM_CH; c++) f[c] = 32767;
        send_frame(f);
        idle(3);
        for (int c = 0; c < NUM_CH; c++) write_w(1'b0, c, -128);
        for (int c = 0; c < NUM_CH; c++) f[c] = -32768;
        send_frame(f);
        idle(3);
        for (int c = 0; c < NUM_CH; c++) f[c] = 32767;
        send_frame(f);
        idle(3);
        check_val("sat_neg_hold", longint'(bus.feat_x), -32768);

        // Restore a mixed weight set for the remaining frames.
        for (int c = 0; c < NUM_CH; c++) write_w(1'b0, c, (c % 3) - 1 + c);

        // Out of order: 0,1,2,4 aborts to IDLE.
        e0 = n_err_pulse;
        s0 = n_strobe;
        drive(1'b1, 0, 100);
        drive(1'b1, 1, 100);
        drive(1'b1, 2, 100);
        drive(1'b1, 4, 100);
        exp_err++;
        idle(2);
        check_val("ooo_err_pulse", n_err_pulse - e0, 1);
        check_val("ooo_err_count", longint'(bus.err_count), exp_err);
        check_val("ooo_busy", longint'(bus.busy), 0);
        check_val("ooo_no_strobe", n_strobe, s0);
        drive(1'b1, 5, 100);
        idle(1);
        check_val("ooo_idle_ignores", longint'(bus.busy), 0);

        // 0,1 then a full frame: restart on the second channel 0.
        for (int c = 0; c < NUM_CH; c++) f[c] = int'($urandom_range(0, 2000)) - 1000;
        drive(1'b1, 0, 3000);
        drive(1'b1, 1, -3000);
        send_frame(f);
        exp_err++;
        idle(3);
        check_val("restart_err_count", longint'(bus.err_count), exp_err);

        // Timeout: 16 idle cycles after channel 3.
        e0 = n_err_pulse;
        for (int c = 0; c < 4; c++) drive(1'b1, c, 50 * c);
        idle(TIMEOUT);
        check_val("tmo_busy_before", longint'(bus.busy), 1);
        check_val("tmo_err_before", longint'(bus.frame_err), 0);
        idle(1);
        exp_err++;
        check_val("tmo_err_at_edge", longint'(bus.frame_err), 1);
        check_val("tmo_busy_after", longint'(bus.busy), 0);
        drive(1'b1, 4, 77);
        idle(2);
        check_val("tmo_ch4_ignored", longint'(bus.busy), 0);
        check_val("tmo_err_count", longint'(bus.err_count), exp_err);
        check_val("tmo_err_pulses", n_err_pulse - e0, 1);

        // Back-to-back frames with a wy[5] write during channel 5 of frame 1.
        for (int c = 0; c < NUM_CH; c++) begin
            f[c]  = int'($urandom_range(0, 2000)) - 1000;
            f2[c] = int'($urandom_range(0, 2000)) - 1000;
        end
        f[5]  = 800;
        f2[5] = 800;
        send_frame(f, 5, 1'b1, 5, 50);
        send_frame(f2);
        idle(4);
        check_val("b2b_spacing",
                  (strobe_cyc.size() >= 2) ? longint'(strobe_cyc[$] - strobe_cyc[$-1]) : -1, 8);

        // Reset mid-frame after channel 3.
        e0 = n_err_pulse;
        for (int c = 0; c < 4; c++) drive(1'b1, c, 400 + c);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check_val("mrst_feat_valid", longint'(bus.feat_valid), 0);
        check_val("mrst_frame_err", longint'(bus.frame_err), 0);
        check_val("mrst_feat_x", longint'(bus.feat_x), 0);
        check_val("mrst_feat_y", longint'(bus.feat_y), 0);
        check_val("mrst_err_count", longint'(bus.err_count), 0);
        check_val("mrst_busy", longint'(bus.busy), 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int c = 0; c < NUM_CH; c++) f[c] = int'($urandom_range(0, 2000)) - 1000;
        send_frame(f);
        idle(4);
        check_val("mrst_no_err", n_err_pulse - e0, 0);
        check_val("mrst_err_count_after", longint'(bus.err_count), exp_err);

        check_val("sb_drained", longint'(sb.size()), 0);
        check_val("strobe_total", n_strobe, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
